// File: rtl/line_prefetch_buffer.sv
// line_prefetch_buffer: single-entry next-line prefetch buffer between L2 and physical memory.
// Defining LINE_PREFETCH_BUFFER_PREFETCH_EN builds the prefetch entry.
// Without it, every read is a pmem pass-through.
module line_prefetch_buffer #(
  parameter int unsigned OFFSET_BITS = 5
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [31:0]                   L2_addr,
  input  logic                          L2_read,
  input  logic                          L2_write,
  input  logic [(8 << OFFSET_BITS)-1:0] L2_wdata,
  output logic [(8 << OFFSET_BITS)-1:0] L2_rdata,
  output logic                          L2_resp,
  output logic [31:0]                   pmem_addr,
  output logic                          pmem_read,
  output logic                          pmem_write,
  output logic [(8 << OFFSET_BITS)-1:0] pmem_wdata,
  input  logic [(8 << OFFSET_BITS)-1:0] pmem_rdata,
  input  logic                          pmem_resp
);

`ifdef LINE_PREFETCH_BUFFER_PREFETCH_EN
  localparam logic [31:0] LINE_BYTES = 32'd1 << OFFSET_BITS;

  typedef enum logic [2:0] {IDLE, HIT_RESP, DEMAND_READ, PREFETCH, WRITE_THRU} state_e;

  logic                          buf_valid_q, buf_valid_d;
  logic [31:0]                   buf_tag_q, buf_tag_d;
  logic [(8 << OFFSET_BITS)-1:0] buf_data_q, buf_data_d;
  logic [31:0]                   pf_addr_q, pf_addr_d;
  logic                          buf_hit;

  assign buf_hit = buf_valid_q && (buf_tag_q == L2_addr);
`else
  typedef enum logic [2:0] {IDLE, DEMAND_READ, WRITE_THRU} state_e;
`endif

  state_e state_q, state_d;

  assign pmem_wdata = L2_wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

`ifdef LINE_PREFETCH_BUFFER_PREFETCH_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_valid_q <= 1'b0;
      buf_tag_q   <= '0;
      buf_data_q  <= '0;
      pf_addr_q   <= '0;
    end else begin
      buf_valid_q <= buf_valid_d;
      buf_tag_q   <= buf_tag_d;
      buf_data_q  <= buf_data_d;
      pf_addr_q   <= pf_addr_d;
    end
  end
`endif

  always_comb begin
    state_d    = state_q;
    L2_rdata   = '0;
    L2_resp    = 1'b0;
    pmem_addr  = '0;
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
`ifdef LINE_PREFETCH_BUFFER_PREFETCH_EN
    buf_valid_d = buf_valid_q;
    buf_tag_d   = buf_tag_q;
    buf_data_d  = buf_data_q;
    pf_addr_d   = pf_addr_q;
`endif
    case (state_q)
      IDLE: begin
        if (L2_read) begin
`ifdef LINE_PREFETCH_BUFFER_PREFETCH_EN
          state_d = buf_hit ? HIT_RESP : DEMAND_READ;
`else
          state_d = DEMAND_READ;
`endif
        end else if (L2_write) begin
          state_d = WRITE_THRU;
`ifdef LINE_PREFETCH_BUFFER_PREFETCH_EN
          // Invalidate on write entry so a later hit can never return stale data.
          if (buf_tag_q == L2_addr) begin
            buf_valid_d = 1'b0;
          end
`endif
        end
      end
`ifdef LINE_PREFETCH_BUFFER_PREFETCH_EN
      HIT_RESP: begin
        L2_resp     = 1'b1;
        L2_rdata    = buf_data_q;
        pf_addr_d   = L2_addr + LINE_BYTES;
        buf_valid_d = 1'b0;
        state_d     = PREFETCH;
      end
      PREFETCH: begin
        pmem_read = 1'b1;
        pmem_addr = pf_addr_q;
        if (pmem_resp) begin
          buf_data_d  = pmem_rdata;
          buf_tag_d   = pf_addr_q;
          buf_valid_d = 1'b1;
          state_d     = IDLE;
        end
      end
`endif
      DEMAND_READ: begin
        pmem_read = 1'b1;
        pmem_addr = L2_addr;
        L2_rdata  = pmem_rdata;
        L2_resp   = pmem_resp;
        if (pmem_resp) begin
`ifdef LINE_PREFETCH_BUFFER_PREFETCH_EN
          pf_addr_d = L2_addr + LINE_BYTES;
          state_d   = PREFETCH;
`else
          state_d   = IDLE;
`endif
        end
      end
      WRITE_THRU: begin
        pmem_write = 1'b1;
        pmem_addr  = L2_addr;
        L2_resp    = pmem_resp;
        if (pmem_resp) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_line_prefetch_buffer.sv
// Self-checking bench for line_prefetch_buffer (follows LINE_PREFETCH_BUFFER_PREFETCH_EN).
module tb_line_prefetch_buffer;

`ifdef LINE_PREFETCH_BUFFER_PREFETCH_EN
  localparam bit PF = 1'b1;
`else
  localparam bit PF = 1'b0;
`endif
  localparam logic [31:0] LINE = 32'd32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [31:0]  L2_addr;
  logic         L2_read, L2_write;
  logic [255:0] L2_wdata, L2_rdata;
  logic         L2_resp;
  logic [31:0]  pmem_addr;
  logic         pmem_read, pmem_write;
  logic [255:0] pmem_wdata, pmem_rdata;
  logic         pmem_resp;

  always #5 clk = ~clk;

  line_prefetch_buffer #(.OFFSET_BITS(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .L2_addr(L2_addr), .L2_read(L2_read), .L2_write(L2_write),
    .L2_wdata(L2_wdata), .L2_rdata(L2_rdata), .L2_resp(L2_resp),
    .pmem_addr(pmem_addr), .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  typedef struct {
    bit           wr;
    logic [31:0]  addr;
    logic [255:0] data;
    int unsigned  need;
  } op_t;

  typedef struct {
    logic [255:0] data;
    bit           hit;
  } rsp_t;

  int unsigned n_assert = 0;
  int unsigned n_fail = 0;

  // Reference: buffer contents and a sparse memory image.
  bit           mvalid;
  logic [31:0]  mtag;
  logic [255:0] mdata;
  logic [255:0] mem [logic [31:0]];

  function automatic logic [255:0] mem_rd(input logic [31:0] a);
    logic [255:0] v;
    if (mem.exists(a)) return mem[a];
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = a ^ (32'h0101_0101 * i) ^ 32'hC0DE_0000;
    return v;
  endfunction

  function automatic logic [255:0] rand_line();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic run(input bit rd, input bit wr, input logic [31:0] a, input logic [255:0] wd);
    op_t ops[$];
    rsp_t rsps[$];
    op_t o;
    op_t cur;
    rsp_t r;
    int unsigned rsp_seen = 0;
    int unsigned lat = 0;
    int unsigned cyc = 0;
    bit busy = 0, sched = 0, driving = 0, drop = 0, done = 0;

    if (rd) begin
      if (PF && mvalid && mtag == a) begin
        r.data = mdata; r.hit = 1'b1; rsps.push_back(r);
      end else begin
        o.wr = 1'b0; o.addr = a; o.data = '0; o.need = 0; ops.push_back(o);
        r.data = mem_rd(a); r.hit = 1'b0; rsps.push_back(r);
      end
      if (PF) begin
        o.wr = 1'b0; o.addr = a + LINE; o.data = '0; o.need = 1; ops.push_back(o);
        mvalid = 1'b1; mtag = a + LINE; mdata = mem_rd(a + LINE);
      end
    end
    if (wr) begin
      o.wr = 1'b1; o.addr = a; o.data = wd; o.need = rd ? 1 : 0; ops.push_back(o);
      r.data = '0; r.hit = 1'b0; rsps.push_back(r);
      if (mtag == a) mvalid = 1'b0;
    end

    @(negedge clk);
    L2_addr = a; L2_read = rd; L2_write = wr; L2_wdata = wd;
    while (!done) begin
      if (cyc != 0) begin
        @(negedge clk);
        if (driving) begin
          pmem_resp = 1'b0; pmem_rdata = rand_line(); busy = 0; driving = 0;
        end
        if (sched) begin
          pmem_resp = 1'b1;
          pmem_rdata = cur.wr ? rand_line() : mem_rd(cur.addr);
          if (cur.wr) mem[cur.addr] = cur.data;
          sched = 0; driving = 1;
        end
        if (drop) begin
          if (L2_read) L2_read = 1'b0;
          else L2_write = 1'b0;
          drop = 0;
        end
      end
      #1;
      check("rw_excl", pmem_read && pmem_write, 0);
      check("wdata_pass", pmem_wdata, L2_wdata);
      if (!L2_read) check("rdata_zero", L2_rdata, 0);
      if (!L2_read && !L2_write) check("resp_idle", L2_resp, 0);
      if (L2_resp) begin
        check("resp_expected", rsps.size() != 0, 1);
        if (rsps.size() != 0) begin
          r = rsps.pop_front();
          check("resp_data", L2_rdata, r.data);
          if (r.hit) check("hit_latency", cyc, 1);
          rsp_seen++;
          drop = 1;
        end
      end
      if (busy) begin
        check("pmem_hold", {pmem_read, pmem_write, pmem_addr}, {!cur.wr, cur.wr, cur.addr});
        if (!sched && !driving) begin
          if (lat == 0) sched = 1;
          else lat--;
        end
      end else if (pmem_read || pmem_write) begin
        check("pmem_expected", ops.size() != 0, 1);
        if (ops.size() != 0) begin
          cur = ops.pop_front();
          check("pmem_kind", {pmem_read, pmem_write}, {!cur.wr, cur.wr});
          check("pmem_addr", pmem_addr, cur.addr);
          if (cur.wr) check("pmem_wdata", pmem_wdata, cur.data);
          check("pmem_order", rsp_seen >= cur.need, 1);
          busy = 1;
          lat = $urandom_range(0, 3);
          if (lat == 0) sched = 1;
          else lat--;
        end
      end
      if (ops.size() == 0 && rsps.size() == 0 && !busy && !sched && !driving && !drop &&
          !L2_read && !L2_write) done = 1;
      cyc++;
      if (cyc > 300) done = 1;
    end
    check("txn_complete", ops.size() + rsps.size(), 0);
    if (ops.size() + rsps.size() != 0) begin
      L2_read = 1'b0; L2_write = 1'b0; pmem_resp = 1'b0;
      rst_n = 1'b0; mvalid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
    end
    repeat (2) begin
      @(negedge clk);
      #1;
      check("quiet", {pmem_read, pmem_write, L2_resp}, 0);
    end
  endtask

  // Reset in PREFETCH (or DEMAND_READ when prefetch is compiled out).
  task automatic reset_mid(input logic [31:0] a);
    int unsigned phase = 0;
    @(negedge clk);
    L2_addr = a; L2_read = 1'b1; L2_write = 1'b0; L2_wdata = rand_line();
    for (int c = 0; c < 40 && phase < 3; c++) begin
      if (c != 0) begin
        @(negedge clk);
        if (phase == 1) begin pmem_resp = 1'b1; pmem_rdata = mem_rd(a); end
        if (phase == 2) begin pmem_resp = 1'b0; pmem_rdata = rand_line(); L2_read = 1'b0; end
      end
      #1;
      if (phase == 0 && pmem_read) begin
        check("rst_demand_addr", pmem_addr, a);
        phase = PF ? 1 : 3;
      end else if (phase == 1) begin
        check("rst_demand_resp", {L2_resp, L2_rdata}, {1'b1, mem_rd(a)});
        phase = 2;
      end else if (phase == 2) begin
        check("rst_pf_start", {pmem_read, pmem_addr}, {1'b1, a + LINE});
        phase = 3;
      end
    end
    check("rst_reached", phase, 3);
    rst_n = 1'b0;
    mvalid = 1'b0;
    #1;
    check("rst_outs_now", {L2_rdata, L2_resp, pmem_addr, pmem_read, pmem_write}, 0);
    @(negedge clk);
    #1;
    check("rst_outs_held", {L2_rdata, L2_resp, pmem_addr, pmem_read, pmem_write}, 0);
    L2_read = 1'b0; pmem_resp = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] a;
    int unsigned k;
    rst_n = 1'b0; L2_addr = '0; L2_read = 1'b0; L2_write = 1'b0; L2_wdata = rand_line();
    pmem_rdata = '0; pmem_resp = 1'b0;
    mvalid = 1'b0; mtag = '0; mdata = '0;
    repeat (2) @(negedge clk);
    L2_read = 1'b1;
    #1;
    check("reset_outs", {L2_rdata, L2_resp, pmem_addr, pmem_read, pmem_write}, 0);
    check("reset_wdata", pmem_wdata, L2_wdata);
    @(negedge clk);
    L2_read = 1'b0;
    rst_n = 1'b1;

    run(1'b1, 1'b0, 32'h0000_0100, rand_line());
    run(1'b1, 1'b0, 32'h0000_0120, rand_line());
    run(1'b0, 1'b1, 32'h0000_0140, rand_line());
    run(1'b1, 1'b0, 32'h0000_0140, rand_line());
    run(1'b1, 1'b0, 32'hFFFF_FFE0, rand_line());
    run(1'b1, 1'b0, 32'h0000_0000, rand_line());
    run(1'b1, 1'b1, 32'h0000_2000, rand_line());
    reset_mid(32'h0000_3000);
    run(1'b1, 1'b0, PF ? 32'h0000_3020 : 32'h0000_3000, rand_line());

    for (int n = 0; n < 40; n++) begin
      k = $urandom_range(0, 9);
      a = $urandom & 32'hFFFF_FFE0;
      if (k < 3 && mvalid) a = mtag;
      if (k == 9) a = mtag;
      if (k < 5) run(1'b1, 1'b0, a, rand_line());
      else if (k < 8 || k == 9) run(1'b0, 1'b1, a, rand_line());
      else run(1'b1, 1'b1, a, rand_line());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
